exp4_unidade_controle_rodadas: RTL and testbench
================================================

Name: exp4_unidade_controle_rodadas

Overview:
- Moore control unit that sequences the memory-game datapath over multiple rounds.
- Datapath blocks under its control: address counter (E), round-limit counter (L), switch register (R), comparator against memory.
- Round N requires the player to enter N values. Each entry is gated by a play pulse from the datapath edge detector and bounded by an internal inactivity timeout.
- Sits beside the datapath in the experiment top level; its outputs drive datapath enables and the result LEDs.

Parameters:
- TIMEOUT_CYCLES, 5000: clock cycles allowed in ESPERA before a timeout (5 s at 1 kHz).
- TIMER_WIDTH, 13: width of the internal timeout counter; must hold TIMEOUT_CYCLES-1.

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high
- iniciar  input  1  start or restart game (level, sampled)
- jogada  input  1  one-cycle pulse: player entered a value
- igual  input  1  comparator: registered value equals memory word
- fimE  input  1  address counter equals round limit
- fimL  input  1  round-limit counter at last round
- zeraE  output  1  clear address counter
- contaE  output  1  increment address counter
- zeraL  output  1  clear round-limit counter
- contaL  output  1  increment round-limit counter
- zeraR  output  1  clear switch register
- registraR  output  1  load switch register
- pronto  output  1  game finished
- acertou  output  1  game won
- errou  output  1  game lost (wrong value)
- timeout  output  1  game lost (inactivity)
- db_estado  output  4  current state code, debug

Behaviour:
- Reset:
  - reset is asynchronous, active-high; clock is clock.
  - Reset forces state INICIAL (0x0) and timer 0.
  - Outputs while in INICIAL: zeraE=zeraL=zeraR=1; all other outputs 0; db_estado=0x0.
  - A reset in any state, including mid-round, aborts immediately with no further datapath pulses.
- States (db_estado code, asserted outputs, transitions):
  - INICIAL (0x0), zeraE/zeraL/zeraR: iniciar=1 -> PREPARACAO, else stay.
  - PREPARACAO (0x1), zeraE/zeraL/zeraR: -> INICIO_RODADA.
  - INICIO_RODADA (0x2), zeraE: -> ESPERA.
  - ESPERA (0x3), no outputs:
    - jogada=1 -> REGISTRA.
    - else timer==TIMEOUT_CYCLES-1 -> FIM_TIMEOUT.
    - else stay.
    - jogada has priority when both conditions occur in the same cycle.
  - REGISTRA (0x4), registraR: -> COMPARACAO.
  - COMPARACAO (0x5), no outputs:
    - igual=0 -> FIM_ERRO.
    - igual=1, fimE=0 -> PROXIMO.
    - igual=1, fimE=1, fimL=0 -> PROXIMA_RODADA.
    - igual=1, fimE=1, fimL=1 -> FIM_ACERTO.
  - PROXIMO (0x6), contaE: -> ESPERA.
  - PROXIMA_RODADA (0x7), contaL: -> INICIO_RODADA.
  - FIM_ACERTO (0xA), pronto+acertou: iniciar=1 -> PREPARACAO, else stay.
  - FIM_ERRO (0xE), pronto+errou: iniciar=1 -> PREPARACAO, else stay.
  - FIM_TIMEOUT (0xD), pronto+timeout: iniciar=1 -> PREPARACAO, else stay.
  - Illegal encodings: next state INICIAL; db_estado=0xF.
- Outputs:
  - All outputs are pure Moore functions of the state; no input-to-output combinational paths.
  - Exactly one of acertou/errou/timeout is high whenever pronto=1.
- Timer:
  - Increments by 1 on each clock while in ESPERA.
  - Held at 0 in every other state, so each entry into ESPERA starts a fresh window.
  - ESPERA therefore lasts at most TIMEOUT_CYCLES cycles.
  - jogada arriving on the cycle where timer==TIMEOUT_CYCLES-1 is accepted.
- Ignored inputs:
  - jogada is ignored outside ESPERA.
  - iniciar is ignored outside INICIAL and the three FIM states.
- Per-value latency: jogada in ESPERA -> registraR on the next cycle -> comparison one cycle later -> contaE one cycle after that.

Test Plan:
- Reset and idle: assert reset mid-ESPERA -> db_estado=0x0 immediately, zeraE=zeraL=zeraR=1, pronto=0; without iniciar, state stays 0x0 for 20 cycles.
- Full win (TIMEOUT_CYCLES=8, 2 rounds):
  - iniciar, then jogada with igual=1 each time.
  - Round 1: fimE=1 on the first value.
  - Round 2: fimE=0 then 1, with fimL=1.
  - Required: states 0,1,2,3,4,5,7,2,3,4,5,6,3,4,5,A; contaL pulses once, contaE once.
  - FIM_ACERTO: pronto=acertou=1.
- Wrong value: second entry of round 2 with igual=0 -> state 0xE, pronto=errou=1, acertou=timeout=0; holds until iniciar, then 0x1.
- Timeout (TIMEOUT_CYCLES=8): no jogada after entering ESPERA -> exactly 8 cycles in 0x3, then 0xD with pronto=timeout=1.
- Boundary: jogada on the 8th ESPERA cycle -> REGISTRA, no timeout; after PROXIMO the timer restarts, with 8 more cycles allowed.
- Ignored inputs: jogada pulses in REGISTRA/COMPARACAO/PROXIMO cause no extra registraR; iniciar mid-round has no effect.

Source files
------------

// File: rtl/exp4_unidade_controle_rodadas.sv
// Moore control unit for the multi-round memory game: sequences the datapath
// counters/register per round and flags win, wrong value or inactivity timeout.
module exp4_unidade_controle_rodadas #(
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int TIMER_WIDTH    = 13
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada,
  input  logic       igual,
  input  logic       fimE,
  input  logic       fimL,
  output logic       zeraE,
  output logic       contaE,
  output logic       zeraL,
  output logic       contaL,
  output logic       zeraR,
  output logic       registraR,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    INICIAL        = 4'h0,
    PREPARACAO     = 4'h1,
    INICIO_RODADA  = 4'h2,
    ESPERA         = 4'h3,
    REGISTRA       = 4'h4,
    COMPARACAO     = 4'h5,
    PROXIMO        = 4'h6,
    PROXIMA_RODADA = 4'h7,
    FIM_ACERTO     = 4'hA,
    FIM_TIMEOUT    = 4'hD,
    FIM_ERRO       = 4'hE
  } estado_t;

  localparam logic [TIMER_WIDTH-1:0] TIMER_MAX = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);

  estado_t                estado;
  estado_t                prox;
  logic [TIMER_WIDTH-1:0] timer;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) estado <= INICIAL;
    else       estado <= prox;
  end

  // Timer only runs in ESPERA, so every entry into ESPERA gets a fresh window.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                 timer <= '0;
    else if (estado != ESPERA) timer <= '0;
    else if (timer != TIMER_MAX) timer <= timer + 1'b1;
  end

  always_comb begin
    prox = INICIAL;
    case (estado)
      INICIAL, FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT:
        prox = iniciar ? PREPARACAO : estado;
      PREPARACAO:     prox = INICIO_RODADA;
      INICIO_RODADA:  prox = ESPERA;
      ESPERA: begin
        if (jogada)                 prox = REGISTRA;
        else if (timer == TIMER_MAX) prox = FIM_TIMEOUT;
        else                        prox = ESPERA;
      end
      REGISTRA:       prox = COMPARACAO;
      COMPARACAO: begin
        if (!igual)     prox = FIM_ERRO;
        else if (!fimE) prox = PROXIMO;
        else if (!fimL) prox = PROXIMA_RODADA;
        else            prox = FIM_ACERTO;
      end
      PROXIMO:        prox = ESPERA;
      PROXIMA_RODADA: prox = INICIO_RODADA;
      default:        prox = INICIAL;
    endcase
  end

  // Pure Moore decode; unknown encodings show 0xF on the debug port.
  always_comb begin
    zeraE     = 1'b0;
    contaE    = 1'b0;
    zeraL     = 1'b0;
    contaL    = 1'b0;
    zeraR     = 1'b0;
    registraR = 1'b0;
    pronto    = 1'b0;
    acertou   = 1'b0;
    errou     = 1'b0;
    timeout   = 1'b0;
    db_estado = 4'hF;
    case (estado)
      INICIAL, PREPARACAO: begin
        zeraE = 1'b1; zeraL = 1'b1; zeraR = 1'b1; db_estado = estado;
      end
      INICIO_RODADA:  begin zeraE = 1'b1;     db_estado = estado; end
      ESPERA:         begin                   db_estado = estado; end
      REGISTRA:       begin registraR = 1'b1; db_estado = estado; end
      COMPARACAO:     begin                   db_estado = estado; end
      PROXIMO:        begin contaE = 1'b1;    db_estado = estado; end
      PROXIMA_RODADA: begin contaL = 1'b1;    db_estado = estado; end
      FIM_ACERTO:     begin pronto = 1'b1; acertou = 1'b1; db_estado = estado; end
      FIM_ERRO:       begin pronto = 1'b1; errou   = 1'b1; db_estado = estado; end
      FIM_TIMEOUT:    begin pronto = 1'b1; timeout = 1'b1; db_estado = estado; end
      default:        db_estado = 4'hF;
    endcase
  end

endmodule

// File: tb/tb_exp4_unidade_controle_rodadas.sv
// Bench for the round control unit: game-level reference model checked every
// cycle, directed game scenarios with literal expectations, then random play.
module tb_exp4_unidade_controle_rodadas;

  localparam int TMO = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       iniciar = 1'b0, jogada = 1'b0, igual = 1'b0, fimE = 1'b0, fimL = 1'b0;
  logic       zeraE, contaE, zeraL, contaL, zeraR, registraR;
  logic       pronto, acertou, errou, timeout;
  logic [3:0] db_estado;

  int checks = 0;
  int errors = 0;

  exp4_unidade_controle_rodadas #(.TIMEOUT_CYCLES(TMO), .TIMER_WIDTH(13)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .jogada(jogada),
    .igual(igual), .fimE(fimE), .fimL(fimL),
    .zeraE(zeraE), .contaE(contaE), .zeraL(zeraL), .contaL(contaL),
    .zeraR(zeraR), .registraR(registraR), .pronto(pronto),
    .acertou(acertou), .errou(errou), .timeout(timeout), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  // Game-level reference: where the game is, and how long the player has idled.
  localparam int IDLE = 0, SETUP = 1, ROUND = 2, WAIT = 3, LATCH = 4, CHECK = 5,
                 ADVANCE = 6, NEXTRND = 7, WON = 8, LOST = 9, SLEPT = 10;
  int ph = IDLE;
  int waited = 0;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      ph = IDLE; waited = 0;
    end else begin
      case (ph)
        IDLE, WON, LOST, SLEPT: if (iniciar) ph = SETUP;
        SETUP:   ph = ROUND;
        ROUND:   begin ph = WAIT; waited = 0; end
        WAIT: begin
          if (jogada) ph = LATCH;
          else if (waited + 1 >= TMO) ph = SLEPT;
          else waited++;
        end
        LATCH:   ph = CHECK;
        CHECK:   ph = !igual ? LOST : (!fimE ? ADVANCE : (!fimL ? NEXTRND : WON));
        ADVANCE: begin ph = WAIT; waited = 0; end
        NEXTRND: ph = ROUND;
        default: ph = IDLE;
      endcase
    end
  end

  // {zeraE,contaE,zeraL,contaL,zeraR,registraR,pronto,acertou,errou,timeout,db}
  function automatic logic [13:0] exp_out(input int p);
    logic [3:0] code [0:10];
    logic [9:0] f;
    code = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'hA, 4'hE, 4'hD};
    f = '0;
    if (p == IDLE || p == SETUP) f = 10'b1010100000;
    if (p == ROUND)   f = 10'b1000000000;
    if (p == ADVANCE) f = 10'b0100000000;
    if (p == NEXTRND) f = 10'b0001000000;
    if (p == LATCH)   f = 10'b0000010000;
    if (p == WON)     f = 10'b0000001100;
    if (p == LOST)    f = 10'b0000001010;
    if (p == SLEPT)   f = 10'b0000001001;
    return {f, code[p]};
  endfunction

  always @(negedge clock) begin
    logic [13:0] act, exp;
    act = {zeraE, contaE, zeraL, contaL, zeraR, registraR, pronto, acertou, errou, timeout, db_estado};
    exp = exp_out(ph);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL model_outputs t=%0t actual=%h expected=%h", $time, act, exp);
    end
    if (pronto === 1'b1) begin
      checks++;
      if ($countones({acertou, errou, timeout}) != 1) begin
        errors++;
        $display("FAIL one_result t=%0t actual=%b%b%b expected=one-hot", $time, acertou, errou, timeout);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  logic [3:0] seen [$];
  int nE, nL, nR;

  // Apply inputs for one edge, then record the resulting state and pulses.
  task automatic go(input bit ij, input bit jg, input bit ig, input bit fe, input bit fl);
    iniciar = ij; jogada = jg; igual = ig; fimE = fe; fimL = fl;
    tick();
    seen.push_back(db_estado);
    nE += contaE; nL += contaL; nR += registraR;
  endtask

  initial begin
    logic [3:0] win_seq [0:15];
    int n;
    win_seq = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h7, 4'h2,
                4'h3, 4'h4, 4'h5, 4'h6, 4'h3, 4'h4, 4'h5, 4'hA};
    #1 reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    chk("reset_state", db_estado, 4'h0);
    chk("reset_zeros", {zeraE, zeraL, zeraR, pronto}, 4'b1110);

    // Full two-round win.
    seen.delete(); nE = 0; nL = 0; nR = 0;
    seen.push_back(db_estado);
    go(1,0,0,0,0); go(0,0,0,0,0); go(0,0,0,0,0); go(0,1,0,0,0);
    go(0,0,1,1,0); go(0,0,1,1,0); go(0,0,0,0,0); go(0,0,0,0,0);
    go(0,1,0,0,0); go(0,0,1,0,0); go(0,0,1,0,0); go(0,0,0,0,0);
    go(0,1,0,0,0); go(0,0,1,1,1); go(0,0,1,1,1);
    for (int i = 0; i < 16; i++) chk($sformatf("win_seq_%0d", i), seen[i], win_seq[i]);
    chk("win_contaL", nL, 1);
    chk("win_contaE", nE, 1);
    chk("win_result", {pronto, acertou, errou, timeout}, 4'b1100);

    // Wrong value on the second entry of round 2.
    go(1,0,0,0,0); chk("restart", db_estado, 4'h1);
    go(0,0,0,0,0); go(0,0,0,0,0); go(0,1,0,0,0); go(0,0,1,1,0); go(0,0,1,1,0);
    go(0,0,0,0,0); go(0,0,0,0,0); go(0,1,0,0,0); go(0,0,1,0,0); go(0,0,1,0,0);
    go(0,0,0,0,0); go(0,1,0,0,0); go(0,0,0,1,0); go(0,0,0,1,0);
    chk("err_state", db_estado, 4'hE);
    chk("err_result", {pronto, acertou, errou, timeout}, 4'b1010);
    for (int i = 0; i < 5; i++) go(0,1,1,1,1);
    chk("err_hold", db_estado, 4'hE);
    go(1,0,0,0,0); chk("err_restart", db_estado, 4'h1);

    // Timeout: count cycles spent in ESPERA.
    go(0,0,0,0,0); go(0,0,0,0,0);
    n = 0;
    while (db_estado == 4'h3 && n < 50) begin n++; go(0,0,0,0,0); end
    chk("tmo_cycles", n, TMO);
    chk("tmo_state", db_estado, 4'hD);
    chk("tmo_result", {pronto, acertou, errou, timeout}, 4'b1001);

    // Boundary: jogada on the last allowed ESPERA cycle, twice in one round.
    go(1,0,0,0,0); go(0,0,0,0,0); go(0,0,0,0,0);
    for (int i = 1; i < TMO; i++) go(0,0,0,0,0);
    chk("bnd_wait1", db_estado, 4'h3);
    go(0,1,0,0,0); chk("bnd_accept1", db_estado, 4'h4);
    go(0,0,1,0,0); go(0,0,1,0,0); go(0,0,0,0,0);
    chk("bnd_back", db_estado, 4'h3);
    for (int i = 1; i < TMO; i++) go(0,0,0,0,0);
    chk("bnd_wait2", db_estado, 4'h3);
    go(0,1,0,0,0); chk("bnd_accept2", db_estado, 4'h4);

    // Ignored inputs: jogada held and iniciar asserted mid-round.
    nR = 0;
    go(1,1,1,0,0); go(1,1,1,0,0); go(1,1,1,0,0);
    chk("ign_state", db_estado, 4'h3);
    chk("ign_registraR", nR, 0);
    go(1,1,0,0,0); chk("ign_accept", db_estado, 4'h4);
    go(0,0,1,0,0); go(0,0,1,0,0); go(0,0,0,0,0);

    // Reset mid-ESPERA takes effect immediately, then idles.
    chk("pre_reset", db_estado, 4'h3);
    reset = 1'b1; #1;
    chk("async_reset_state", db_estado, 4'h0);
    chk("async_reset_out", {zeraE, zeraL, zeraR, pronto}, 4'b1110);
    tick(); reset = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin go(0,1,1,1,1); if (db_estado == 4'h0) n++; end
    chk("idle_20", n, 20);

    // Random play against the reference model.
    for (int i = 0; i < 3000; i++) begin
      iniciar = ($urandom_range(0, 9) == 0);
      jogada  = ($urandom_range(0, 5) == 0);
      igual   = ($urandom_range(0, 9) != 0);
      fimE    = ($urandom_range(0, 2) == 0);
      fimL    = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 299) == 0) begin
        reset = 1'b1; #1;
        chk("rand_async_reset", db_estado, 4'h0);
        tick(); reset = 1'b0;
      end else begin
        tick();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
